// File: rtl/pico_pkg.sv
// Shared decode types, opcode constants and the instruction decode function
// used by the picoMIPS decode stage.
package pico_pkg;

  localparam int PKG_OPCODE_W = 6;
  localparam int PKG_OFFSET_W = 5;
  localparam int PKG_IMM_W    = 5;
  localparam int PKG_INSTR_W  = 16;
  localparam int PKG_ADDR_W   = 5;

  localparam logic [PKG_OPCODE_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [PKG_OPCODE_W-1:0] OP_MUL  = 6'b000001;
  localparam logic [PKG_OPCODE_W-1:0] OP_ADD  = 6'b000010;
  localparam logic [PKG_OPCODE_W-1:0] OP_NEXT = 6'b000011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [PKG_OPCODE_W-1:0]        opcode;
    logic signed [PKG_OFFSET_W-1:0] offset;
    logic [PKG_IMM_W-1:0]           imm;
    logic [PKG_ADDR_W-1:0]          addr;
    logic                           is_nop;
    logic                           is_mul;
    logic                           is_add;
    logic                           is_next;
    logic                           illegal;
  } decoded_t;

  // addr uses the sample index as it stood before this instruction
  function automatic decoded_t decode_fn(input logic [PKG_INSTR_W-1:0] instr,
                                         input logic [PKG_ADDR_W-1:0]  i);
    decoded_t                       d;
    logic signed [PKG_OFFSET_W-1:0] off;
    d        = '0;
    off      = instr[PKG_IMM_W +: PKG_OFFSET_W];
    d.opcode = instr[PKG_INSTR_W-1 -: PKG_OPCODE_W];
    d.offset = off;
    d.imm    = instr[PKG_IMM_W-1:0];
    d.addr   = i + PKG_ADDR_W'(off);
    case (d.opcode)
      OP_NOP:  d.is_nop  = 1'b1;
      OP_MUL:  d.is_mul  = 1'b1;
      OP_ADD:  d.is_add  = 1'b1;
      OP_NEXT: d.is_next = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pico_skid_buf.sv
// Two-entry valid/ready register slice; full throughput with registered
// in_ready and out_valid.
module pico_skid_buf
  import pico_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         push_s, pop_s;

  assign push_s = in_valid && in_ready_q;
  assign pop_s  = out_valid_q && out_ready;

  // next-state and datapath steering for the two entries
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    skid_d     = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          out_data_d = in_data;
          state_d    = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          out_data_d = in_data;
        end else if (push_s) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else if (pop_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          out_data_d = skid_q;
          state_d    = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/pico_decode_stage.sv
// Registered, handshaked picoMIPS instruction decode stage.
// Optional DECODE_ILLEGAL_TRAP_EN: swallow illegal opcodes and raise illegal_seen.
module pico_decode_stage
  import pico_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int OFFSET_W = 5,
  parameter int IMM_W    = 5,
  parameter int INSTR_W  = 16,
  parameter int ADDR_W   = 5
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPCODE_W-1:0]        opcode,
  output logic signed [OFFSET_W-1:0] offset,
  output logic [IMM_W-1:0]           imm,
  output logic [ADDR_W-1:0]          addr,
  output logic                       is_nop,
  output logic                       is_mul,
  output logic                       is_add,
  output logic                       is_next,
  output logic                       illegal,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                       illegal_seen,
`endif
  output logic [ADDR_W-1:0]          sample_idx
);

  // the decoded_t payload is laid out with the package widths
  if ((INSTR_W != OPCODE_W + OFFSET_W + IMM_W) || (ADDR_W < OFFSET_W) ||
      (OPCODE_W != PKG_OPCODE_W) || (OFFSET_W != PKG_OFFSET_W) ||
      (IMM_W != PKG_IMM_W) || (ADDR_W != PKG_ADDR_W)) begin : g_param_err
    $error("pico_decode_stage: inconsistent field widths");
  end

  decoded_t          dec_s, out_dec_s;
  logic              accept_s, fwd_valid_s, buf_ready_s;
  logic [ADDR_W-1:0] idx_q, idx_d;

  assign dec_s    = decode_fn(instr, idx_q);
  assign accept_s = in_valid && buf_ready_s;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic seen_q, seen_d;
  assign fwd_valid_s  = in_valid && !dec_s.illegal;
  assign illegal_seen = seen_q;
`else
  assign fwd_valid_s  = in_valid;
`endif

  // sample index advances when a NEXT is accepted
  always_comb begin
    if (accept_s && dec_s.is_next) begin
      idx_d = idx_q + 5'd1;
    end else begin
      idx_d = idx_q;
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (accept_s && dec_s.illegal) begin
      seen_d = 1'b1;
    end else begin
      seen_d = seen_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      idx_q  <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      seen_q <= 1'b0;
`endif
    end else begin
      idx_q  <= idx_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
      seen_q <= seen_d;
`endif
    end
  end

  pico_skid_buf #(.W($bits(decoded_t))) u_skid (
    .clk       (clk),
    .n_reset   (n_reset),
    .in_valid  (fwd_valid_s),
    .in_ready  (buf_ready_s),
    .in_data   (dec_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_dec_s)
  );

  assign in_ready   = buf_ready_s;
  assign opcode     = out_dec_s.opcode;
  assign offset     = out_dec_s.offset;
  assign imm        = out_dec_s.imm;
  assign addr       = out_dec_s.addr;
  assign is_nop     = out_dec_s.is_nop;
  assign is_mul     = out_dec_s.is_mul;
  assign is_add     = out_dec_s.is_add;
  assign is_next    = out_dec_s.is_next;
  assign illegal    = out_dec_s.illegal;
  assign sample_idx = idx_q;

endmodule

// File: tb/tb_pico_decode_stage.sv
// Self-checking bench for pico_decode_stage: queue-based reference model,
// directed scenarios and randomized traffic.
module tb_pico_decode_stage;

  logic              clk = 1'b0;
  logic              n_reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [15:0]       instr = 16'h0000;
  logic              in_ready, out_valid;
  logic [5:0]        opcode;
  logic signed [4:0] offset;
  logic [4:0]        imm, addr, sample_idx;
  logic              is_nop, is_mul, is_add, is_next, illegal;
  logic              illegal_seen_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pico_decode_stage dut (
    .clk(clk), .n_reset(n_reset),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .offset(offset), .imm(imm), .addr(addr),
    .is_nop(is_nop), .is_mul(is_mul), .is_add(is_add), .is_next(is_next),
    .illegal(illegal),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal_seen(illegal_seen_s),
`endif
    .sample_idx(sample_idx)
  );

`ifndef DECODE_ILLEGAL_TRAP_EN
  assign illegal_seen_s = 1'b0;
`endif

  typedef struct {
    int opc; int off; int imm; int addr;
    int nop; int mul; int add; int nxt; int ill;
  } exp_t;

  exp_t q[$];
  int   m_i = 0;
  int   m_seen = 0;
  bit   trap = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_decode(input logic [15:0] w, input int i);
    exp_t e;
    e.opc  = int'(w[15:10]);
    e.off  = int'(w[9:5]);
    if (e.off >= 16) e.off = e.off - 32;
    e.imm  = int'(w[4:0]);
    e.addr = (i + e.off + 32) % 32;
    e.nop  = (e.opc == 0) ? 1 : 0;
    e.mul  = (e.opc == 1) ? 1 : 0;
    e.add  = (e.opc == 2) ? 1 : 0;
    e.nxt  = (e.opc == 3) ? 1 : 0;
    e.ill  = (e.opc > 3) ? 1 : 0;
    return e;
  endfunction

  // reference model: at most two pending beats, drain happens before fill
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      q.delete();
      m_i = 0;
      m_seen = 0;
    end else begin
      bit   drain, acc;
      exp_t e;
      drain = (q.size() > 0) && out_ready;
      acc   = in_valid && (q.size() < 2);
      e     = model_decode(instr, m_i);
      if (drain) void'(q.pop_front());
      if (acc) begin
        if (trap && e.ill == 1) m_seen = 1;
        else q.push_back(e);
        if (e.nxt == 1) m_i = (m_i + 1) % 32;
      end
    end
  end

  always @(negedge clk) begin
    if (n_reset) begin
      chk("in_ready", int'(in_ready), (q.size() < 2) ? 1 : 0);
      chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      chk("sample_idx", int'(sample_idx), m_i);
      if (trap) chk("illegal_seen", int'(illegal_seen_s), m_seen);
      if (out_valid && q.size() > 0) begin
        chk("opcode", int'(opcode), q[0].opc);
        chk("offset", int'(offset), q[0].off);
        chk("imm", int'(imm), q[0].imm);
        chk("addr", int'(addr), q[0].addr);
        chk("class", int'({is_nop, is_mul, is_add, is_next, illegal}),
            q[0].nop * 16 + q[0].mul * 8 + q[0].add * 4 + q[0].nxt * 2 + q[0].ill);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    n_reset = 1'b1;
    step();
  endtask

  localparam logic [15:0] I_NEXT = 16'b000011_00000_00000;

  initial begin
`ifdef DECODE_ILLEGAL_TRAP_EN
    trap = 1'b1;
`endif
    do_reset();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fields", int'({opcode, imm, addr, is_nop, illegal}), 0);
    chk("rst_sample_idx", int'(sample_idx), 0);

    // MUL offset -2 at i=0
    in_valid = 1'b1; instr = 16'b000001_11110_00000; step(); in_valid = 1'b0;
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_is_mul", int'(is_mul), 1);
    chk("t1_offset", int'(offset), -2);
    chk("t1_imm", int'(imm), 0);
    chk("t1_addr", int'(addr), 30);

    // three NEXT then MUL offset -1
    in_valid = 1'b1; instr = I_NEXT;
    for (int k = 0; k < 3; k++) step();
    instr = 16'b000001_11111_00001; step(); in_valid = 1'b0;
    chk("t2_sample_idx", int'(sample_idx), 3);
    chk("t2_addr", int'(addr), 2);
    chk("t2_imm", int'(imm), 1);

    // 32 back-to-back NEXT wraps the index
    do_reset();
    in_valid = 1'b1; instr = I_NEXT;
    for (int k = 0; k < 32; k++) step();
    in_valid = 1'b0;
    chk("t3_last_addr", int'(addr), 31);
    chk("t3_sample_idx", int'(sample_idx), 0);
    step();

    // back-pressure: two accepted, third waits
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 16'b000001_00000_00001; step();
    instr = 16'b000010_00000_00010; step();
    chk("t4_in_ready_low", int'(in_ready), 0);
    instr = 16'b000000_00000_00011; step(); step();
    chk("t4_stable_imm", int'(imm), 1);
    chk("t4_stable_mul", int'(is_mul), 1);
    out_ready = 1'b1; step();
    chk("t4_second_imm", int'(imm), 2);
    step(); in_valid = 1'b0;
    chk("t4_third_imm", int'(imm), 3);
    step();

    // illegal opcode
    in_valid = 1'b1; instr = 16'hFC00; step(); in_valid = 1'b0;
    if (trap) begin
      chk("t5_no_beat", int'(out_valid), 0);
      chk("t5_seen", int'(illegal_seen_s), 1);
    end else begin
      chk("t5_beat", int'(out_valid), 1);
      chk("t5_illegal", int'(illegal), 1);
      chk("t5_not_nop", int'(is_nop), 0);
    end
    step();

    // reset while holding two entries
    out_ready = 1'b0; in_valid = 1'b1; instr = I_NEXT;
    step(); step(); in_valid = 1'b0;
    chk("t6_pre_in_ready", int'(in_ready), 0);
    n_reset = 1'b0; #1;
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    chk("t6_sample_idx", int'(sample_idx), 0);
    step();
    n_reset = 1'b1; out_ready = 1'b1; step();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr = 16'($urandom);
      if (sel < 8) instr[15:10] = 6'(sel % 4);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_decode_stage.md
# pico_decode_stage

Registered, handshaked instruction-decode stage for the picoMIPS datapath, replacing the purely combinational field splitter. Accepts fetched instructions on a valid/ready interface, splits them into parametrised opcode/offset/immediate fields, classifies the opcode, and computes the circular sample-buffer address `(i + offset) mod 2^ADDR_W` against an internal sample index `i` that the NEXT instruction advances. It sits between fetch and the MUL/ADD execute stage. A two-entry skid buffer gives full throughput under back-pressure.

## Interface
- `OPCODE_W`, default 6: opcode field width, bits [INSTR_W-1 -: OPCODE_W].
- `OFFSET_W`, default 5: signed two's-complement offset field width, next field down.
- `IMM_W`, default 5: unsigned immediate (coefficient index) width, LSBs.
- `INSTR_W`, default 16: instruction width; must equal OPCODE_W+OFFSET_W+IMM_W, otherwise elaboration fails.
- `ADDR_W`, default 5: sample-buffer address width (depth 2^ADDR_W); ADDR_W ≥ OFFSET_W.
- `clk` in 1: clock, rising edge.
- `n_reset` in 1: asynchronous active-low reset.
- `in_valid` in 1 / `in_ready` out 1 / `instr` in INSTR_W: upstream handshake.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `opcode` out OPCODE_W; `offset` out signed OFFSET_W; `imm` out IMM_W: raw fields.
- `addr` out ADDR_W: computed sample address.
- `is_nop`, `is_mul`, `is_add`, `is_next`, `illegal` out 1 each: one-hot class.
- `sample_idx` out ADDR_W: current value of `i`.
- `illegal_seen` out 1: sticky flag, only with `DECODE_ILLEGAL_TRAP_EN`.

## Operation
- Opcodes: NOP=000000, MUL=000001, ADD=000010, NEXT=000011. Every other value is illegal. Exactly one class bit is set per output beat.
- Transfer occurs when valid && ready on the same edge. Upstream and downstream are independent.
- Decode happens at accept. `addr = (i + sext(offset)) mod 2^ADDR_W`, using `i` before any update by this same instruction.
- An accepted NEXT sets `i <= (i + 1) mod 2^ADDR_W`. 31 wraps to 0. Its own `addr` uses the old `i`.
- Skid buffer FSM:
  - EMPTY, accept -> ONE.
  - ONE, accept and no drain -> TWO.
  - ONE, accept and drain -> ONE.
  - ONE, drain only -> EMPTY.
  - TWO, drain -> ONE; the skid entry moves to the output register.
- `in_ready = (state != TWO)` and comes from a register.
- While `out_valid && !out_ready`, every output field stays stable.
- Reset mid-operation flushes both entries. Accepted-but-undrained instructions are lost, and `i` returns to 0.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle when `out_ready` stays high.
- Reset values:
  - `in_ready=1`, `out_valid=0`.
  - All fields, class bits, `addr`, `sample_idx` = 0.
  - `illegal_seen=0`. State is EMPTY.
- `in_ready` drops the cycle after the second entry fills. It rises the cycle after a drain from TWO.
- `sample_idx` updates on the edge that accepts NEXT.
- Simultaneous accept and drain in ONE keeps the state at ONE with no bubble.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - Illegal instructions are accepted but not forwarded; no output beat is produced.
  - `illegal_seen` is set on the next edge and holds until reset.
- Not defined:
  - Illegal instructions are forwarded with `illegal=1` and all other class bits 0.
  - `addr` is still computed for them.
  - The `illegal_seen` port is absent.

## Structure
- Package `pico_pkg` holds:
  - opcode localparams (OP_NOP, OP_MUL, OP_ADD, OP_NEXT);
  - the `decoded_t` packed struct (fields, class bits, addr);
  - the `decode_fn` function (instr, i -> decoded_t).
- Sub-module `pico_skid_buf`: generic 2-entry valid/ready register slice, parametrised on payload width, carrying `decoded_t`.

## Test plan
- Reset, then MUL `000001_11110_00000` with `i=0` -> one cycle later `out_valid=1`, `is_mul=1`, `offset=-2`, `imm=0`, `addr=30`.
- Three NEXT instructions, then MUL `000001_11111_00001` -> `sample_idx=3`, `addr=2`, `imm=1`.
- 32 back-to-back NEXT with `out_ready=1` -> no bubbles; `sample_idx` passes 31 and wraps to 0; the last beat's `addr=31`.
- `out_ready=0` while feeding 3 instructions -> 2 accepted, `in_ready=0`, outputs stable. Raise `out_ready` -> both drain in order, then the third is accepted.
- Opcode `111111`:
  - with the macro -> no beat and `illegal_seen=1`;
  - without the macro -> beat with `illegal=1`.
- Assert `n_reset` while in TWO -> immediately `out_valid=0`, `in_ready=1`, `sample_idx=0`.
